// File: rtl/dport_in_pkg.sv
// Shared constants and request decode for the debug input port.
// Address values and status bit positions also feed the output-port decode.
package dport_in_pkg;

    localparam logic [15:0] DPORT_DATA_ADDR = 16'h4000;
    localparam logic [15:0] DPORT_STAT_ADDR = 16'h4001;

    localparam int STAT_NE_BIT    = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_UF_BIT    = 7;
    localparam int CTRL_FLUSH_BIT = 0;

    typedef struct packed {
        logic pop;
        logic stat;
        logic flush;
    } port_req_t;

    function automatic port_req_t decode_req(
        input logic [15:0] addr,
        input logic        re,
        input logic        we,
        input logic [7:0]  wdata,
        input logic [15:0] data_addr,
        input logic [15:0] stat_addr
    );
        port_req_t r;
        r.pop   = re && (addr == data_addr);
        r.stat  = re && (addr == stat_addr);
        r.flush = we && (addr == stat_addr) && wdata[CTRL_FLUSH_BIT];
        return r;
    endfunction

    function automatic logic [7:0] stat_byte(
        input logic not_empty,
        input logic full,
        input logic underflow
    );
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_NE_BIT]   = not_empty;
        s[STAT_FULL_BIT] = full;
        s[STAT_UF_BIT]   = underflow;
        return s;
    endfunction

endpackage

// File: rtl/dport_in_fifo.sv
// Byte FIFO with one push and up to two pops per cycle.
// Exposes head and head+1 so both core ports can pop together.
module dport_in_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic [1:0]  pops,
    input  logic        flush,
    output logic [7:0]  head,
    output logic [7:0]  head1,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [7:0]    mem_q [2**AW];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        rd_d  = rd_q + AW'(pops);
        wr_d  = wr_q;
        cnt_d = cnt_q - (AW+1)'(pops);
        if (push) begin
            wr_d  = wr_q + AW'(1);
            cnt_d = cnt_d + (AW+1)'(1);
        end
        // Flush drops any same-cycle push; the byte was still handshaken.
        if (flush) begin
            rd_d  = wr_q;
            wr_d  = wr_q;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_q];
    assign head1 = mem_q[rd_q + AW'(1)];
    assign count = cnt_q;
    assign full  = cnt_q[AW];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/dport_in.sv
// Memory-mapped debug input port: host pushes bytes, core pops via 0x4000.
// Read data is registered and zero when this block was not selected.
module dport_in
    import dport_in_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] DATA_ADDR  = DPORT_DATA_ADDR,
    parameter logic [15:0] STAT_ADDR  = DPORT_STAT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr1,
    input  logic [15:0] addr2,
    input  logic        re1,
    input  logic        re2,
    input  logic        we1,
    input  logic        we2,
    input  logic [7:0]  data_in1,
    input  logic [7:0]  data_in2,
    output logic [7:0]  data_out1,
    output logic [7:0]  data_out2,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int CW = DEPTH_LOG2 + 1;

    port_req_t     req1, req2;
    logic [7:0]    head, head1;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, flush;
    logic [1:0]    pops;
    logic          uf_set, uf_clr;
    logic [7:0]    stat;
    logic          uf_q, uf_d;
    logic [7:0]    dout1_q, dout1_d;
    logic [7:0]    dout2_q, dout2_d;

    dport_in_fifo #(.AW(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pops  (pops),
        .flush (flush),
        .head  (head),
        .head1 (head1),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        req1 = decode_req(addr1, re1, we1, data_in1,
                          DATA_ADDR, STAT_ADDR);
        req2 = decode_req(addr2, re2, we2, data_in2,
                          DATA_ADDR, STAT_ADDR);
        push    = in_valid && !full;
        flush   = req1.flush || req2.flush;
        stat    = stat_byte(!empty, full, uf_q);
        dout1_d = 8'h00;
        dout2_d = 8'h00;
        pops    = 2'd0;
        uf_set  = 1'b0;
        uf_clr  = req1.stat || req2.stat || flush;
        if (req1.pop) begin
            if (!empty) begin
                dout1_d = head;
                pops    = 2'd1;
            end else begin
                uf_set = 1'b1;
            end
        end
        // Port 2 takes the byte behind whatever port 1 consumed.
        if (req2.pop) begin
            if (req1.pop && count >= CW'(2)) begin
                dout2_d = head1;
                pops    = 2'd2;
            end else if (!req1.pop && !empty) begin
                dout2_d = head;
                pops    = 2'd1;
            end else begin
                uf_set = 1'b1;
            end
        end
        if (req1.stat) dout1_d = stat;
        if (req2.stat) dout2_d = stat;
        uf_d = uf_clr ? 1'b0 : uf_q;
        if (uf_set) uf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uf_q    <= 1'b0;
            dout1_q <= 8'h00;
            dout2_q <= 8'h00;
        end else begin
            uf_q    <= uf_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
        end
    end

    assign data_out1 = dout1_q;
    assign data_out2 = dout2_q;
    assign in_ready  = !full;

endmodule
